posit_encoder: RTL and testbench

//  Encodes a normalised posit result (sign, signed scale factor, mantissa product) back to a WIDTH-bit posit word.

---
 rtl/posit_pkg.sv | 19 +
 rtl/posit_regime_pack.sv | 36 +++
 rtl/posit_encoder.sv | 177 +++++++++++++++++
 tb/tb_posit_encoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit constants and width helpers for the decoder, mult and encoder stages.
package posit_pkg;

  localparam int P_WIDTH = 8;
  localparam int P_EXP   = 2;
  localparam int P_REGI  = $clog2(P_WIDTH) + 1;
  localparam int P_MTS   = P_WIDTH - 3 - P_EXP;
  localparam int P_SFW   = P_REGI + P_EXP + 1;
  localparam int P_PRODW = 2 * (P_MTS + 1);

  localparam logic [P_WIDTH-1:0] NAR  = {1'b1, {(P_WIDTH-1){1'b0}}};
  localparam logic [P_WIDTH-1:0] ZERO = '0;

  // Largest scale factor representable without clamping (regime of all ones).
  function automatic int maxpos_sf(input int width, input int exp);
    return (width - 2) << exp;
  endfunction

endpackage

// File: rtl/posit_regime_pack.sv
// Combinational pack: builds {regime, exponent, fraction}, keeps the top WIDTH-1 bits
// as the posit body and reduces the dropped bits to guard and sticky.
module posit_regime_pack
  import posit_pkg::*;
#(
  parameter int WIDTH = P_WIDTH,
  parameter int EXP   = P_EXP,
  parameter int FRW   = 2 * (WIDTH - 3 - EXP) + 1,
  parameter int KW    = P_SFW + 1 - P_EXP
) (
  input  logic signed [KW-1:0]    k_i,
  input  logic        [EXP-1:0]   e_i,
  input  logic        [FRW-1:0]   frac_i,
  output logic        [WIDTH-2:0] body_o,
  output logic                    guard_o,
  output logic                    sticky_o
);

  // Wide enough that the longest regime never pushes fraction bits off the end.
  localparam int PW = WIDTH + EXP + FRW;

  logic        [KW-1:0] sh;
  logic signed [PW-1:0] base;
  logic signed [PW-1:0] field;

  // "10" shifted arithmetically by k grows the ones-run; "01" by -k-1 grows the zeros-run.
  always_comb begin
    sh       = k_i[KW-1] ? ~k_i : k_i;
    base     = {(k_i[KW-1] ? 2'b01 : 2'b10), e_i, frac_i, {(WIDTH-2){1'b0}}};
    field    = base >>> sh;
    body_o   = field[PW-1 -: WIDTH-1];
    guard_o  = field[PW-WIDTH];
    sticky_o = |field[PW-WIDTH-1:0];
  end

endmodule

// File: rtl/posit_encoder.sv
// Three-stage posit encoder: normalise/clamp, regime pack, round-nearest-even and sign.
// Optional sat_o output when POSIT_ENC_SAT_FLAG_EN is defined.
module posit_encoder
  import posit_pkg::*;
#(
  parameter int WIDTH = P_WIDTH,
  parameter int EXP   = P_EXP,
  parameter int REGI  = $clog2(WIDTH) + 1,
  parameter int MTS   = WIDTH - 3 - EXP,
  parameter int SFW   = REGI + EXP + 1
) (
  input  logic                    clk_i,
  input  logic                    rstn,
  input  logic                    vld_i,
  output logic                    rdy_o,
  input  logic                    sign_i,
  input  logic signed [SFW-1:0]   sf_i,
  input  logic [2*(MTS+1)-1:0]    mts_i,
  input  logic                    zero_i,
  input  logic                    nar_i,
  output logic                    vld_o,
  input  logic                    rdy_i,
  output logic [WIDTH-1:0]        posit_o
`ifdef POSIT_ENC_SAT_FLAG_EN
  ,
  output logic                    sat_o
`endif
);

  localparam int PRODW = 2 * (MTS + 1);
  localparam int FRW   = 2 * MTS + 1;
  localparam int KW    = SFW + 1 - EXP;

  localparam logic signed [SFW:0]   MAXSF  = (SFW+1)'(maxpos_sf(WIDTH, EXP));
  localparam logic signed [SFW:0]   MINSF  = -MAXSF;
  localparam logic [WIDTH-2:0]      MAXPOS = {(WIDTH-1){1'b1}};
  localparam logic [WIDTH-2:0]      MINPOS = {{(WIDTH-2){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]      NAR_W  = {NAR[P_WIDTH-1], {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]      ZERO_W = {WIDTH{ZERO[0]}};

  function automatic logic [WIDTH-1:0] round_rne(input logic [WIDTH-2:0] b,
                                                 input logic g, input logic s);
    return {1'b0, b} + WIDTH'(g & (s | b[0]));
  endfunction

  function automatic logic [WIDTH-2:0] sat_body(input logic [WIDTH-1:0] r);
    return r[WIDTH-1] ? MAXPOS : r[WIDTH-2:0];
  endfunction

  logic en;

  logic                    vld_p0_q, vld_p0_d, sign_p0_q, sign_p0_d;
  logic                    zero_p0_q, zero_p0_d, nar_p0_q, nar_p0_d;
  logic                    hi_p0_q, hi_p0_d, lo_p0_q, lo_p0_d;
  logic signed [KW-1:0]    k_p0_q, k_p0_d;
  logic [EXP-1:0]          e_p0_q, e_p0_d;
  logic [FRW-1:0]          frac_p0_q, frac_p0_d;

  logic                    vld_p1_q, vld_p1_d, sign_p1_q, sign_p1_d;
  logic                    zero_p1_q, zero_p1_d, nar_p1_q, nar_p1_d;
  logic                    hi_p1_q, hi_p1_d, lo_p1_q, lo_p1_d;
  logic [WIDTH-2:0]        body_p1_q, body_p1_d;
  logic                    guard_p1_q, guard_p1_d, sticky_p1_q, sticky_p1_d;

  logic                    vld_q, vld_d;
  logic [WIDTH-1:0]        posit_q, posit_d;

  logic signed [SFW:0]     sf_n;
  logic [WIDTH-2:0]        pack_body;
  logic                    pack_guard, pack_sticky;
  logic [WIDTH-1:0]        rnd;
  logic [WIDTH-2:0]        body_s3;

  assign en      = rdy_i | ~vld_q;
  assign rdy_o   = en;
  assign vld_o   = vld_q;
  assign posit_o = posit_q;

  posit_regime_pack #(
    .WIDTH (WIDTH),
    .EXP   (EXP),
    .FRW   (FRW),
    .KW    (KW)
  ) u_pack (
    .k_i      (k_p0_q),
    .e_i      (e_p0_q),
    .frac_i   (frac_p0_q),
    .body_o   (pack_body),
    .guard_o  (pack_guard),
    .sticky_o (pack_sticky)
  );

  always_comb begin
    vld_p0_d  = vld_p0_q;  sign_p0_d = sign_p0_q;  zero_p0_d = zero_p0_q;
    nar_p0_d  = nar_p0_q;  hi_p0_d   = hi_p0_q;    lo_p0_d   = lo_p0_q;
    k_p0_d    = k_p0_q;    e_p0_d    = e_p0_q;     frac_p0_d = frac_p0_q;
    vld_p1_d  = vld_p1_q;  sign_p1_d = sign_p1_q;  zero_p1_d = zero_p1_q;
    nar_p1_d  = nar_p1_q;  hi_p1_d   = hi_p1_q;    lo_p1_d   = lo_p1_q;
    body_p1_d = body_p1_q; guard_p1_d = guard_p1_q; sticky_p1_d = sticky_p1_q;
    vld_d     = vld_q;     posit_d   = posit_q;

    // S1: normalise a 1x.f product and split the scale factor into regime k and exponent e
    sf_n = {sf_i[SFW-1], sf_i} + {{SFW{1'b0}}, mts_i[PRODW-1]};

    // S3: round, saturate, apply sign, then let the special cases win
    rnd = round_rne(body_p1_q, guard_p1_q, sticky_p1_q);
    if (hi_p1_q)      body_s3 = MAXPOS;
    else if (lo_p1_q) body_s3 = MINPOS;
    else              body_s3 = sat_body(rnd);

    if (en) begin
      vld_p0_d  = vld_i;
      sign_p0_d = sign_i;
      zero_p0_d = zero_i;
      nar_p0_d  = nar_i;
      hi_p0_d   = sf_n > MAXSF;
      lo_p0_d   = sf_n < MINSF;
      k_p0_d    = sf_n[SFW:EXP];
      e_p0_d    = sf_n[EXP-1:0];
      frac_p0_d = mts_i[PRODW-1] ? mts_i[2*MTS:0] : {mts_i[2*MTS-1:0], 1'b0};

      // S2: register the packed body alongside the clamp and special flags
      vld_p1_d    = vld_p0_q;
      sign_p1_d   = sign_p0_q;
      zero_p1_d   = zero_p0_q;
      nar_p1_d    = nar_p0_q;
      hi_p1_d     = hi_p0_q;
      lo_p1_d     = lo_p0_q;
      body_p1_d   = pack_body;
      guard_p1_d  = pack_guard;
      sticky_p1_d = pack_sticky;

      vld_d = vld_p1_q;
      if (nar_p1_q)       posit_d = NAR_W;
      else if (zero_p1_q) posit_d = ZERO_W;
      else if (sign_p1_q) posit_d = -{1'b0, body_s3};
      else                posit_d = {1'b0, body_s3};
    end
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      vld_p0_q  <= 1'b0; sign_p0_q <= 1'b0; zero_p0_q <= 1'b0; nar_p0_q <= 1'b0;
      hi_p0_q   <= 1'b0; lo_p0_q   <= 1'b0; k_p0_q    <= '0;   e_p0_q   <= '0;
      frac_p0_q <= '0;
      vld_p1_q  <= 1'b0; sign_p1_q <= 1'b0; zero_p1_q <= 1'b0; nar_p1_q <= 1'b0;
      hi_p1_q   <= 1'b0; lo_p1_q   <= 1'b0; body_p1_q <= '0;
      guard_p1_q <= 1'b0; sticky_p1_q <= 1'b0;
      vld_q     <= 1'b0; posit_q   <= '0;
    end else begin
      vld_p0_q  <= vld_p0_d;  sign_p0_q <= sign_p0_d; zero_p0_q <= zero_p0_d;
      nar_p0_q  <= nar_p0_d;  hi_p0_q   <= hi_p0_d;   lo_p0_q   <= lo_p0_d;
      k_p0_q    <= k_p0_d;    e_p0_q    <= e_p0_d;    frac_p0_q <= frac_p0_d;
      vld_p1_q  <= vld_p1_d;  sign_p1_q <= sign_p1_d; zero_p1_q <= zero_p1_d;
      nar_p1_q  <= nar_p1_d;  hi_p1_q   <= hi_p1_d;   lo_p1_q   <= lo_p1_d;
      body_p1_q <= body_p1_d; guard_p1_q <= guard_p1_d; sticky_p1_q <= sticky_p1_d;
      vld_q     <= vld_d;     posit_q   <= posit_d;
    end
  end

`ifdef POSIT_ENC_SAT_FLAG_EN
  logic sat_q, sat_d;

  always_comb begin
    sat_d = sat_q;
    if (en) sat_d = ~nar_p1_q & ~zero_p1_q & (hi_p1_q | lo_p1_q | rnd[WIDTH-1]);
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end

  assign sat_o = sat_q;
`endif

endmodule

// File: tb/tb_posit_encoder.sv
// Self-checking bench for posit_encoder (WIDTH=8, EXP=2); also covers sat_o when
// POSIT_ENC_SAT_FLAG_EN is defined.
module tb_posit_encoder;
  import posit_pkg::*;

  logic                      clk_i, rstn, vld_i, rdy_o, sign_i, zero_i, nar_i;
  logic                      vld_o, rdy_i;
  logic signed [P_SFW-1:0]   sf_i;
  logic [P_PRODW-1:0]        mts_i;
  logic [7:0]                posit_o;
  logic                      sat_obs;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

`ifdef POSIT_ENC_SAT_FLAG_EN
  localparam bit HAS_SAT = 1'b1;
  logic sat_o;
  assign sat_obs = sat_o;
`else
  localparam bit HAS_SAT = 1'b0;
  assign sat_obs = 1'b0;
`endif

  posit_encoder dut (
    .clk_i   (clk_i),
    .rstn    (rstn),
    .vld_i   (vld_i),
    .rdy_o   (rdy_o),
    .sign_i  (sign_i),
    .sf_i    (sf_i),
    .mts_i   (mts_i),
    .zero_i  (zero_i),
    .nar_i   (nar_i),
    .vld_o   (vld_o),
    .rdy_i   (rdy_i),
    .posit_o (posit_o)
`ifdef POSIT_ENC_SAT_FLAG_EN
    ,
    .sat_o   (sat_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: write out the posit bit string explicitly, then round it to 7 body bits.
  function automatic logic [8:0] ref_posit(input bit s, input int sf_in, input int mts,
                                           input bit z, input bit n);
    bit q[$];
    int sf, f, k, e, body, res;
    bit g, st, sat;
    sat = 0;
    sf  = sf_in;
    if (n) return {1'b0, 8'h80};
    if (z) return 9'h000;
    if (mts >= 128) begin sf = sf + 1; f = mts - 128; end
    else f = (mts - 64) * 2;
    if (sf > 24) begin body = 127; sat = 1; end
    else if (sf < -24) begin body = 1; sat = 1; end
    else begin
      k = (sf >= 0) ? sf / 4 : -((3 - sf) / 4);
      e = sf - 4 * k;
      if (k >= 0) begin repeat (k + 1) q.push_back(1'b1); q.push_back(1'b0); end
      else begin repeat (-k) q.push_back(1'b0); q.push_back(1'b1); end
      q.push_back(e[1]);
      q.push_back(e[0]);
      for (int i = 6; i >= 0; i--) q.push_back(f[i]);
      while (q.size() < 9) q.push_back(1'b0);
      body = 0;
      for (int i = 0; i < 7; i++) body = body * 2 + int'(q[i]);
      g  = q[7];
      st = 0;
      for (int i = 8; i < q.size(); i++) st = st | q[i];
      if (g && (st || q[6])) body = body + 1;
      if (body == 128) begin body = 127; sat = 1; end
    end
    res = s ? (256 - body) & 255 : body;
    return {sat & HAS_SAT, res[7:0]};
  endfunction

  always @(negedge clk_i) begin
    if (rstn) begin
      if (vld_i && rdy_o)
        exp_q.push_back(ref_posit(sign_i, int'(sf_i), int'(mts_i), zero_i, nar_i));
      if (vld_o && rdy_i) got_q.push_back({sat_obs, posit_o});
    end
  end

  task automatic drive(input bit s, input int sf, input int mts, input bit z, input bit n);
    sign_i = s;
    sf_i   = sf[P_SFW-1:0];
    mts_i  = mts[P_PRODW-1:0];
    zero_i = z;
    nar_i  = n;
  endtask

  task automatic test_reset();
    rstn = 1'b0; vld_i = 1'b0; rdy_i = 1'b1;
    drive(0, 0, 'h40, 0, 0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if (vld_o !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", vld_o); end
    total++;
    if (posit_o !== 8'h00) begin bad++; $display("FAIL reset_posit got=%h want=00", posit_o); end
    total++;
    if (sat_obs !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b want=0", sat_obs); end
    @(posedge clk_i); #1 rstn = 1'b1;
    @(negedge clk_i);
    total++;
    if (rdy_o !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", rdy_o); end
    total++;
    if (vld_o !== 1'b0) begin bad++; $display("FAIL reset_idle_vld got=%b want=0", vld_o); end
  endtask

  typedef struct {
    bit s; int sf; int mts; bit z; bit n; logic [7:0] p; bit sat;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[16];
    int   lat;
    bit   seen;
    tbl = '{
      '{0,   0, 'h40, 0, 0, 8'h40, 0},
      '{1,   0, 'h40, 0, 0, 8'hC0, 0},
      '{0,   0, 'h80, 0, 0, 8'h48, 0},
      '{0,   1, 'h40, 0, 0, 8'h48, 0},
      '{1,   1, 'h40, 0, 0, 8'hB8, 0},
      '{0,   0, 'h44, 0, 0, 8'h40, 0},
      '{0,   0, 'h46, 0, 0, 8'h41, 0},
      '{0,  30, 'h40, 0, 0, 8'h7F, 1},
      '{0, -30, 'h40, 0, 0, 8'h01, 1},
      '{1, -30, 'h40, 0, 0, 8'hFF, 1},
      '{0,   0, 'h40, 1, 1, 8'h80, 0},
      '{0,   0, 'h40, 1, 0, 8'h00, 0},
      '{0,  24, 'h40, 0, 0, 8'h7F, 0},
      '{0, -24, 'h40, 0, 0, 8'h01, 0},
      '{0,  24, 'h80, 0, 0, 8'h7F, 1},
      '{0,  -1, 'h60, 0, 0, 8'h3C, 0}
    };
    rdy_i = 1'b1;
    foreach (tbl[i]) begin
      @(posedge clk_i); #1;
      drive(tbl[i].s, tbl[i].sf, tbl[i].mts, tbl[i].z, tbl[i].n);
      vld_i = 1'b1;
      @(posedge clk_i); #1;
      vld_i = 1'b0;
      lat = 0; seen = 0;
      for (int c = 1; c <= 10 && !seen; c++) begin
        @(negedge clk_i);
        if (vld_o === 1'b1) begin seen = 1; lat = c; end
      end
      total++;
      if (!seen || lat != 3) begin
        bad++; $display("FAIL dir%0d_latency got=%0d want=3", i, lat);
      end
      total++;
      if (posit_o !== tbl[i].p) begin
        bad++; $display("FAIL dir%0d_posit got=%h want=%h", i, posit_o, tbl[i].p);
      end
      if (HAS_SAT) begin
        total++;
        if (sat_obs !== tbl[i].sat) begin
          bad++; $display("FAIL dir%0d_sat got=%b want=%b", i, sat_obs, tbl[i].sat);
        end
      end
    end
    @(posedge clk_i);
  endtask

  task automatic check_queues(input string tag);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL %s_count got=%0d want=%0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL %s_beat%0d got=%h want=%h", tag, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int sf;
    exp_q.delete(); got_q.delete();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk_i); #1;
      sf = int'($urandom_range(0, 56)) - 28;
      drive($urandom_range(0, 1) == 1, sf, int'($urandom_range(64, 255)),
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      vld_i = $urandom_range(0, 3) != 0;
      rdy_i = $urandom_range(0, 3) != 0;
    end
    @(posedge clk_i); #1;
    vld_i = 1'b0; rdy_i = 1'b1;
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    check_queues("rand");
  endtask

  task automatic test_back_to_back();
    int         idx, cyc;
    logic [7:0] held;
    exp_q.delete(); got_q.delete();
    idx = 0; cyc = 0; held = '0;
    @(posedge clk_i); #1;
    while (idx < 5 && cyc < 50) begin
      rdy_i = !(cyc == 4 || cyc == 5);
      vld_i = 1'b1;
      drive(idx[0], idx * 3 - 6, 'h40 + idx * 37, 0, 0);
      @(negedge clk_i);
      if (cyc == 4 || cyc == 5) begin
        total++;
        if (rdy_o !== 1'b0) begin bad++; $display("FAIL stall_rdy c%0d got=%b want=0", cyc, rdy_o); end
        total++;
        if (vld_o !== 1'b1) begin bad++; $display("FAIL stall_vld c%0d got=%b want=1", cyc, vld_o); end
        if (cyc == 4) held = posit_o;
        else begin
          total++;
          if (posit_o !== held) begin bad++; $display("FAIL stall_hold got=%h want=%h", posit_o, held); end
        end
      end
      if (rdy_o) idx++;
      @(posedge clk_i); #1;
      cyc++;
    end
    vld_i = 1'b0; rdy_i = 1'b1;
    repeat (6) @(posedge clk_i);
    @(negedge clk_i);
    check_queues("b2b");
  endtask

  task automatic test_reset_midstream();
    bit leak;
    rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      vld_i = 1'b1;
      drive(0, i, 'h50, 0, 0);
    end
    #2 rstn = 1'b0;
    @(posedge clk_i); #1 vld_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (vld_o !== 1'b0) begin bad++; $display("FAIL midrst_vld got=%b want=0", vld_o); end
    total++;
    if (posit_o !== 8'h00) begin bad++; $display("FAIL midrst_posit got=%h want=00", posit_o); end
    @(posedge clk_i); #1 rstn = 1'b1;
    leak = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (vld_o !== 1'b0) leak = 1;
    end
    total++;
    if (leak) begin bad++; $display("FAIL midrst_flush got=vld_seen want=no_output"); end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
